// File: rtl/buzzer_pkg.sv
// Shared widths and default timing constants for the buzzer input conditioner.
package buzzer_pkg;

  localparam int DEBOUNCE_CNT_W           = 16;
  localparam int STUCK_CNT_W              = 24;
  localparam int DEBOUNCE_CYCLES_DEFAULT  = 1000;
  localparam int STUCK_CYCLES_DEFAULT     = 5000000;

  typedef logic [DEBOUNCE_CNT_W-1:0] db_cnt_t;
  typedef logic [STUCK_CNT_W-1:0]    stuck_cnt_t;

endpackage

// File: rtl/buzzer_debounce.sv
// One buzzer channel: synchronizer, debounce counter, clean level, press pulse
// and sticky stuck-button flag.
import buzzer_pkg::*;

module buzzer_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic press_enable,
  input  logic clear_stuck,
  output logic level,
  output logic press,
  output logic stuck
);

  logic       sync1;
  logic       s;
  db_cnt_t    db_cnt;
  stuck_cnt_t stuck_cnt;
  stuck_cnt_t stuck_next;
  logic       db_done;

  assign db_done = (s != level) && (db_cnt == db_cnt_t'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    stuck_next = stuck_cnt;
    if (stuck_cnt != '1) stuck_next = stuck_cnt + stuck_cnt_t'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      s         <= 1'b0;
      db_cnt    <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      stuck_cnt <= '0;
      stuck     <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;

      if (s == level) begin
        db_cnt <= '0;
      end else if (db_done) begin
        level  <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + db_cnt_t'(1);
      end

      // Pulse lands on the same edge the level rises; enable is sampled there only.
      press <= db_done && s && press_enable;

      if (level) stuck_cnt <= stuck_next;
      else       stuck_cnt <= '0;

      // Counter saturates past the threshold, so a clear while held re-sets next edge.
      if (level && (stuck_next >= stuck_cnt_t'(STUCK_CYCLES))) stuck <= 1'b1;
      else if (clear_stuck)                                      stuck <= 1'b0;
    end
  end

endmodule

// File: rtl/buzzer_conditioner.sv
// Two-player buzzer front end: conditions both raw push-buttons into clean
// levels, press pulses and stuck flags.
import buzzer_pkg::*;

module buzzer_conditioner #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_user1,
  input  logic raw_user2,
  input  logic press_enable,
  input  logic clear_stuck,
  output logic buzzer_user1,
  output logic buzzer_user2,
  output logic press_user1,
  output logic press_user2,
  output logic stuck_user1,
  output logic stuck_user2
);

  buzzer_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_user1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw          (raw_user1),
    .press_enable (press_enable),
    .clear_stuck  (clear_stuck),
    .level        (buzzer_user1),
    .press        (press_user1),
    .stuck        (stuck_user1)
  );

  buzzer_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_user2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw          (raw_user2),
    .press_enable (press_enable),
    .clear_stuck  (clear_stuck),
    .level        (buzzer_user2),
    .press        (press_user2),
    .stuck        (stuck_user2)
  );

endmodule

// File: tb/tb_buzzer_conditioner.sv
// Directed bench for buzzer_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
module tb_buzzer_conditioner;

  localparam int DB = 4;
  localparam int ST = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic raw_user1, raw_user2, press_enable, clear_stuck;
  logic buzzer_user1, buzzer_user2, press_user1, press_user2, stuck_user1, stuck_user2;

  int n_checks = 0;
  int n_fail   = 0;

  buzzer_conditioner #(.DEBOUNCE_CYCLES(DB), .STUCK_CYCLES(ST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_user1    (raw_user1),
    .raw_user2    (raw_user2),
    .press_enable (press_enable),
    .clear_stuck  (clear_stuck),
    .buzzer_user1 (buzzer_user1),
    .buzzer_user2 (buzzer_user2),
    .press_user1  (press_user1),
    .press_user2  (press_user2),
    .stuck_user1  (stuck_user1),
    .stuck_user2  (stuck_user2)
  );

  always #5 clk = ~clk;

  // exp bit order: {buzz1, buzz2, press1, press2, stuck1, stuck2}
  typedef struct {
    logic       raw1;
    logic       raw2;
    logic       en;
    logic       clr;
    int         cycles;
    logic [5:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r1, input logic r2, input logic en, input logic clr,
                     input int cyc, input logic [5:0] exp, input string name);
    vec_t v;
    v.raw1 = r1; v.raw2 = r2; v.en = en; v.clr = clr;
    v.cycles = cyc; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = {buzzer_user1, buzzer_user2, press_user1, press_user2, stuck_user1, stuck_user2};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got b1b2p1p2s1s2=%06b expected %06b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; raw_user1 = 1'b0; raw_user2 = 1'b0;
    press_enable = 1'b1; clear_stuck = 1'b0;

    // Clean press on user1: raw set before edge 0, level rises after edge DB+1.
    add(1,0,1,0,5,6'b000000,"clean_wait");
    add(1,0,1,0,1,6'b101000,"clean_press");
    add(1,0,1,0,3,6'b100000,"clean_hold");
    add(0,0,1,0,5,6'b100000,"clean_rel_wait");
    add(0,0,1,0,1,6'b000000,"clean_rel");
    add(0,0,1,0,2,6'b000000,"idle1");
    // Glitch one sample short of DB never changes the level.
    add(1,0,1,0,3,6'b000000,"glitch_short");
    add(0,0,1,0,6,6'b000000,"glitch_after");
    // Bounce 1,0,1,0 then hold.
    add(1,0,1,0,1,6'b000000,"bounce_1");
    add(0,0,1,0,1,6'b000000,"bounce_0");
    add(1,0,1,0,1,6'b000000,"bounce_1b");
    add(0,0,1,0,1,6'b000000,"bounce_0b");
    add(1,0,1,0,5,6'b000000,"bounce_wait");
    add(1,0,1,0,1,6'b101000,"bounce_press");
    add(1,0,1,0,2,6'b100000,"bounce_hold");
    add(0,0,1,0,5,6'b100000,"bounce_rel_wait");
    add(0,0,1,0,1,6'b000000,"bounce_rel");
    add(0,0,1,0,2,6'b000000,"idle2");
    // Lockout on user2, then enable while held: no replay.
    add(0,1,0,0,5,6'b000000,"lock_wait");
    add(0,1,0,0,1,6'b010000,"lock_level");
    add(0,1,0,0,2,6'b010000,"lock_hold");
    add(0,1,1,0,3,6'b010000,"lock_no_replay");
    add(0,0,1,0,5,6'b010000,"lock_rel_wait");
    add(0,0,1,0,1,6'b000000,"lock_rel");
    add(0,0,1,0,2,6'b000000,"idle3");
    // Simultaneous press on both channels.
    add(1,1,1,0,5,6'b000000,"simul_wait");
    add(1,1,1,0,1,6'b111100,"simul_press");
    add(1,1,1,0,2,6'b110000,"simul_hold");
    add(0,0,1,0,5,6'b110000,"simul_rel_wait");
    add(0,0,1,0,1,6'b000000,"simul_rel");
    add(0,0,1,0,2,6'b000000,"idle4");

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 6'b000000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      raw_user1 = vecs[i].raw1; raw_user2 = vecs[i].raw2;
      press_enable = vecs[i].en; clear_stuck = vecs[i].clr;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        check(vecs[i].name, vecs[i].exp);
      end
    end

    // Stuck flag: level high after edge 5, counter reaches ST at edge 5+ST.
    raw_user1 = 1'b1;
    repeat (DB + 1 + ST) step();
    check("stuck_pre", 6'b100000);
    step();
    check("stuck_set", 6'b100010);
    raw_user1 = 1'b0;
    repeat (5) step();
    check("stuck_rel_wait", 6'b100010);
    step();
    check("stuck_after_rel", 6'b000010);
    repeat (5) step();
    check("stuck_sticky", 6'b000010);
    clear_stuck = 1'b1;
    step();
    clear_stuck = 1'b0;
    check("stuck_clear", 6'b000000);

    // Clear while still held: set wins.
    raw_user1 = 1'b1;
    repeat (DB + 2 + ST) step();
    check("stuck_set2", 6'b100010);
    clear_stuck = 1'b1;
    step();
    clear_stuck = 1'b0;
    check("stuck_clear_held", 6'b100010);
    raw_user1 = 1'b0;
    repeat (6) step();
    check("stuck_rel2", 6'b000010);
    clear_stuck = 1'b1;
    step();
    clear_stuck = 1'b0;
    check("stuck_clear2", 6'b000000);

    // Reset mid-count: user2 debounced high, user1 at count 2.
    raw_user2 = 1'b1;
    repeat (DB + 2) step();
    check("rst_pre_press2", 6'b010100);
    step();
    check("rst_pre_level2", 6'b010000);
    raw_user1 = 1'b1;
    repeat (4) step();
    check("rst_pre_count", 6'b010000);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 6'b000000);
    rst_n = 1'b1;
    repeat (DB + 1) step();
    check("reset_latency", 6'b000000);
    step();
    check("reset_press", 6'b111100);
    step();
    check("reset_hold", 6'b110000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buzzer_conditioner.md
BUZZER_CONDITIONER -- requirements
Module: buzzer_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable synchronized samples required to accept a level change; legal range 1..65535.
REQ-002 Parameter STUCK_CYCLES, default 5000000: consecutive debounced-high cycles after which a button is flagged stuck; legal range 1..2^24-1.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 raw_user1, raw_user2  input  1 each  asynchronous raw push-button levels, active-high, may bounce.
REQ-006 press_enable  input  1  synchronous; when low, press pulses are suppressed (lockout window).
REQ-007 clear_stuck  input  1  synchronous; one-cycle pulse clears both stuck flags.
REQ-008 buzzer_user1, buzzer_user2  output  1 each  clean debounced levels, fed directly to the winner arbiter's buzzer inputs.
REQ-009 press_user1, press_user2  output  1 each  single-cycle press-event pulses.
REQ-010 stuck_user1, stuck_user2  output  1 each  sticky stuck-button flags.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer; the second-stage flop is the sampled value s.
REQ-012 Per channel a debounce counter (16 bit) SHALL clear on any edge where s equals the debounced level d and increment where s differs from d.
REQ-013 On the edge where s differs from d and the counter equals DEBOUNCE_CYCLES-1, d SHALL take the value of s and the counter SHALL clear.
REQ-014 Latency: if edge k is the first to capture raw high into the synchronizer and raw then stays high, d SHALL be high after edge k+DEBOUNCE_CYCLES+1; falling edges take the same latency.
REQ-015 Any bounce that returns s to d before the count completes SHALL restart the count from zero; d never changes on a shorter glitch.
REQ-016 buzzer_userN SHALL equal d of channel N (registered, no combinational path from raw inputs).
REQ-017 press_userN SHALL be high for exactly one cycle, coincident with the first cycle d is high after a 0->1 transition, and only if press_enable was high on the transition edge.
REQ-018 A press suppressed by press_enable low SHALL NOT be replayed when press_enable later rises, even if the button is still held.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on both SHALL produce simultaneous pulses on the same cycle with no priority.
REQ-020 A 24-bit saturating stuck counter per channel SHALL increment each cycle d is high and clear when d is low.
REQ-021 stuck_userN SHALL set on the edge the stuck counter reaches STUCK_CYCLES and remain set until clear_stuck or reset, regardless of d.
REQ-022 If clear_stuck coincides with a set condition, set SHALL win; clear while the button is still held does not restart the counter, so the flag re-sets on the next edge.
REQ-023 Stuck flags SHALL NOT gate press or level outputs.

Reset
REQ-024 While rst_n is low, all synchronizer flops, d, counters, press and stuck outputs SHALL be 0.
REQ-025 After rst_n deasserts with a button already held, the level SHALL rise after the REQ-014 latency and one press pulse SHALL fire if enabled.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count with no output glitch.

Structure
REQ-027 Shared package buzzer_pkg SHALL hold DEBOUNCE_CNT_W=16, STUCK_CNT_W=24 and the default DEBOUNCE_CYCLES/STUCK_CYCLES constants.
REQ-028 One sub-module buzzer_debounce (synchronizer, debounce counter, level, pulse, stuck logic for one channel) SHALL be instantiated twice; press_enable and clear_stuck are shared.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20)
REQ-029 Clean press: raw_user1 0->1 captured at edge 10, held -> buzzer_user1 high after edge 15; press_user1 high only in the cycle after edge 15.
REQ-030 Bounce: raw_user1 toggles 1,0,1,0 on alternating cycles, then holds 1 -> no output change until 4 stable samples; exactly one press pulse.
REQ-031 Lockout: press_enable=0 during user2 press -> buzzer_user2 rises, press_user2 stays 0; raising press_enable while held -> no pulse.
REQ-032 Simultaneous: both raws rise on the same edge -> both press pulses on the same cycle.
REQ-033 Stuck: user1 held 20 cycles after debounce -> stuck_user1 sets and stays after release; clear_stuck pulse -> 0.
REQ-034 Reset: rst_n low for 2 cycles mid-count (count=2) -> all outputs 0 immediately; after release with button held, press fires after the full REQ-014 latency.
